// File: rtl/adc_sample_averager.sv
// adc_sample_averager
//   Sums N signed ADC samples per output word (N = max(averages,1)), with
//   signed 32-bit saturation. Results are queued in a small FIFO and sent out
//   as an AXI4-Stream toward the DMA, framed into packets with tlast.
//   Also feeds flow-control hints back to the trigger controller.
//
// Ports
//   aclk, aresetn        clock / async active-low reset
//   s_sample_data/valid  one-cycle sample strobe, no backpressure
//   averages             samples per output word (0 and 1 both mean 1)
//   packet_len           beats per packet (0: tlast never asserted)
//   clear                synchronous flush of all datapath state
//   m_axis_*             result stream (tdata = saturated signed sum)
//   ready                FIFO has at least 2 free entries (registered)
//   last                 one-cycle pulse, cycle after a tlast handshake
//   overflow             sticky: a result was dropped on a full FIFO
module adc_sample_averager #(
  parameter int DATA_WIDTH = 20,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [DATA_WIDTH-1:0] s_sample_data,
  input  logic                  s_sample_valid,
  input  logic [31:0]           averages,
  input  logic [31:0]           packet_len,
  input  logic                  clear,
  output logic [31:0]           m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  ready,
  output logic                  last,
  output logic                  overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] READY_MAX = CW'(FIFO_DEPTH - 2);

  logic [31:0]   acc;
  logic [31:0]   avg_cnt;
  logic [31:0]   beat_cnt;
  logic [31:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_next;
  logic          last_r, ovf_r, ready_r;

  logic [32:0]   sum_ext;
  logic [31:0]   sum_sat;
  logic [31:0]   n_eff;
  logic          done, push_req, push, pop, drop, full, tlast_c;

  // 33-bit add of sign-extended operands cannot wrap; clamp to 32 bits when
  // the top two bits disagree.
  always_comb begin
    sum_ext = {acc[31], acc} +
              {{(33-DATA_WIDTH){s_sample_data[DATA_WIDTH-1]}}, s_sample_data};
    if (sum_ext[32] != sum_ext[31])
      sum_sat = sum_ext[32] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    else
      sum_sat = sum_ext[31:0];
  end

  // ">=" so that lowering averages mid-word completes on the next sample.
  assign n_eff    = (averages == 32'd0) ? 32'd1 : averages;
  assign done     = avg_cnt >= (n_eff - 32'd1);

  assign full     = (count == DEPTH_C);
  assign m_axis_tvalid = (count != '0);
  assign pop      = m_axis_tvalid & m_axis_tready;
  assign push_req = s_sample_valid & done;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push     = push_req & (~full | pop);
  assign drop     = push_req & full & ~pop;

  assign m_axis_tdata = m_axis_tvalid ? mem[rd_ptr] : 32'd0;
  assign tlast_c  = m_axis_tvalid && (packet_len != 32'd0) &&
                    (beat_cnt >= packet_len - 32'd1);
  assign m_axis_tlast = tlast_c;

  always_comb begin
    count_next = count + CW'(push) - CW'(pop);
    if (clear) count_next = '0;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      acc      <= '0;
      avg_cnt  <= '0;
      beat_cnt <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      last_r   <= 1'b0;
      ovf_r    <= 1'b0;
      ready_r  <= 1'b1;
    end else begin
      ready_r <= (count_next <= READY_MAX);
      if (clear) begin
        acc      <= '0;
        avg_cnt  <= '0;
        beat_cnt <= '0;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        count    <= '0;
        last_r   <= 1'b0;
        ovf_r    <= 1'b0;
      end else begin
        last_r <= pop & tlast_c;
        count  <= count_next;
        if (s_sample_valid) begin
          if (done) begin
            acc     <= '0;
            avg_cnt <= '0;
          end else begin
            acc     <= sum_sat;
            avg_cnt <= avg_cnt + 32'd1;
          end
        end
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
        if (drop) ovf_r  <= 1'b1;
        if (pop)  beat_cnt <= tlast_c ? 32'd0 : beat_cnt + 32'd1;
      end
    end
  end

  // Storage needs no reset: tdata is masked while the FIFO is empty.
  always_ff @(posedge aclk) begin
    if (push && !clear) mem[wr_ptr] <= sum_sat;
  end

  assign ready    = ready_r;
  assign last     = last_r;
  assign overflow = ovf_r;

endmodule

// File: tb/tb_adc_sample_averager.sv
// Directed bench for adc_sample_averager: pass-through framing, averaging,
// backpressure/overflow, clear, saturation and asynchronous reset.
module tb_adc_sample_averager;
  localparam int DW = 20;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic [DW-1:0] s_sample_data = '0;
  logic          s_sample_valid = 1'b0;
  logic [31:0]   averages = 32'd1;
  logic [31:0]   packet_len = 32'd0;
  logic          clear = 1'b0;
  logic [31:0]   m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b1;
  logic          m_axis_tlast;
  logic          ready, last, overflow;

  adc_sample_averager #(.DATA_WIDTH(DW), .FIFO_DEPTH(4)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_sample_data(s_sample_data), .s_sample_valid(s_sample_valid),
    .averages(averages), .packet_len(packet_len), .clear(clear),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .ready(ready), .last(last), .overflow(overflow)
  );

  always #5 aclk = ~aclk;

  int n_chk = 0, n_fail = 0;
  int cyc = 0;
  logic [31:0] q_data[$];
  logic        q_last[$];
  int n_last = 0, last_cyc = -1, tl_cyc = -1;

  always @(posedge aclk) cyc <= cyc + 1;

  // Beat / pulse collector, sampled mid-cycle.
  always @(negedge aclk) begin
    if (m_axis_tvalid && m_axis_tready) begin
      q_data.push_back(m_axis_tdata);
      q_last.push_back(m_axis_tlast);
      if (m_axis_tlast) tl_cyc = cyc;
    end
    if (last) begin
      n_last++;
      last_cyc = cyc;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge aclk); #1; end
  endtask

  task automatic send(input logic [DW-1:0] d);
    s_sample_data = d; s_sample_valid = 1'b1;
    step(1);
    s_sample_valid = 1'b0;
  endtask

  task automatic burst(input logic [DW-1:0] d, input int n);
    s_sample_data = d; s_sample_valid = 1'b1;
    step(n);
    s_sample_valid = 1'b0;
  endtask

  task automatic flush_mon();
    q_data.delete(); q_last.delete();
    n_last = 0; last_cyc = -1; tl_cyc = -1;
  endtask

  task automatic expect_beat(input string tag, input logic [31:0] d, input logic l);
    chk({tag, "_present"}, 32'(q_data.size() != 0), 32'd1);
    if (q_data.size() != 0) begin
      chk({tag, "_data"}, q_data.pop_front(), d);
      chk({tag, "_tlast"}, 32'(q_last.pop_front()), 32'(l));
    end
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_tvalid", 32'(m_axis_tvalid), 0);
    chk("rst_tlast", 32'(m_axis_tlast), 0);
    chk("rst_tdata", m_axis_tdata, 0);
    chk("rst_last", 32'(last), 0);
    chk("rst_ovf", 32'(overflow), 0);
    aresetn = 1'b1;
    step(1);
    chk("rst_ready", 32'(ready), 1);

    // Pass-through, packet of 3
    flush_mon();
    averages = 1; packet_len = 3; m_axis_tready = 1;
    send(20'd5); send(20'hFFFFD); send(20'h7FFFF);
    step(4);
    chk("pt_nbeats", 32'(q_data.size()), 3);
    expect_beat("pt_b0", 32'd5, 0);
    expect_beat("pt_b1", 32'hFFFF_FFFD, 0);
    expect_beat("pt_b2", 32'h0007_FFFF, 1);
    chk("pt_last_cnt", 32'(n_last), 1);
    chk("pt_last_lag", 32'(last_cyc - tl_cyc), 1);

    // Averaging by 4; leftover sample completes when averages drops to 0
    flush_mon();
    averages = 4; packet_len = 0;
    send(20'd10); send(20'd20); send(20'd30); send(20'd40); send(20'd1);
    step(3);
    chk("avg_nbeats", 32'(q_data.size()), 1);
    expect_beat("avg_b0", 32'd100, 0);
    averages = 0;
    send(20'd2);
    send(20'd7);
    step(3);
    expect_beat("avg_rem", 32'd3, 0);
    expect_beat("avg_n0", 32'd7, 0);

    // Backpressure and overflow
    flush_mon();
    m_axis_tready = 0; averages = 1;
    send(20'd11); chk("bp_ready1", 32'(ready), 1);
    send(20'd12); chk("bp_ready2", 32'(ready), 1);
    send(20'd13); chk("bp_ready3", 32'(ready), 0);
    send(20'd14); chk("bp_ready4", 32'(ready), 0);
    chk("bp_ovf4", 32'(overflow), 0);
    chk("bp_tvalid", 32'(m_axis_tvalid), 1);
    send(20'd15); chk("bp_ovf5", 32'(overflow), 1);
    step(2);
    chk("bp_stall_data", m_axis_tdata, 32'd11);
    chk("bp_stall_nbeats", 32'(q_data.size()), 0);
    m_axis_tready = 1;
    step(6);
    chk("bp_nbeats", 32'(q_data.size()), 4);
    expect_beat("bp_b0", 32'd11, 0);
    expect_beat("bp_b1", 32'd12, 0);
    expect_beat("bp_b2", 32'd13, 0);
    expect_beat("bp_b3", 32'd14, 0);
    chk("bp_ready_drained", 32'(ready), 1);
    chk("bp_ovf_sticky", 32'(overflow), 1);

    // Clear with 2 words buffered and a partial sum pending
    flush_mon();
    m_axis_tready = 0; packet_len = 2; averages = 1;
    send(20'd21); send(20'd22);
    averages = 4;
    send(20'd5);
    chk("clr_pre_tvalid", 32'(m_axis_tvalid), 1);
    clear = 1; step(1); clear = 0;
    chk("clr_tvalid", 32'(m_axis_tvalid), 0);
    chk("clr_ovf", 32'(overflow), 0);
    m_axis_tready = 1; averages = 1;
    send(20'd30); send(20'd31);
    step(3);
    expect_beat("clr_b0", 32'd30, 0);
    expect_beat("clr_b1", 32'd31, 1);
    chk("clr_last_cnt", 32'(n_last), 1);
    // clear beats a simultaneous sample strobe
    averages = 2;
    s_sample_data = 20'd100; s_sample_valid = 1; clear = 1;
    step(1);
    s_sample_valid = 0; clear = 0;
    send(20'd1); send(20'd2);
    step(3);
    expect_beat("clr_sim", 32'd3, 0);
    chk("clr_sim_ovf", 32'(overflow), 0);

    // Saturation, positive then negative
    flush_mon();
    packet_len = 0; averages = 5000;
    burst(20'h7FFFF, 4096);
    step(2);
    chk("sat_nbeats_pre", 32'(q_data.size()), 0);
    averages = 3;
    send(20'h7FFFF);
    step(3);
    expect_beat("sat_pos", 32'h7FFF_FFFF, 0);
    averages = 4097;
    burst(20'h80000, 4097);
    step(3);
    expect_beat("sat_neg", 32'h8000_0000, 0);
    chk("sat_ovf", 32'(overflow), 0);

    // Async reset while a beat is pending
    flush_mon();
    m_axis_tready = 0; averages = 1; packet_len = 1;
    send(20'd9);
    chk("ar_pre_tvalid", 32'(m_axis_tvalid), 1);
    chk("ar_pre_tlast", 32'(m_axis_tlast), 1);
    #2 aresetn = 0;
    #1;
    chk("ar_tvalid", 32'(m_axis_tvalid), 0);
    chk("ar_tlast", 32'(m_axis_tlast), 0);
    chk("ar_tdata", m_axis_tdata, 0);
    chk("ar_last", 32'(last), 0);
    @(posedge aclk); #3 aresetn = 1;
    step(1);
    chk("ar_ready", 32'(ready), 1);
    chk("ar_post_tvalid", 32'(m_axis_tvalid), 0);
    m_axis_tready = 1;
    send(20'd6);
    step(3);
    chk("ar_nbeats", 32'(q_data.size()), 1);
    expect_beat("ar_b0", 32'd6, 1);
    chk("ar_last_cnt", 32'(n_last), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
